ela_interp_param: RTL and testbench

- Parametrised successor of the fixed 32-column ELA deinterlacer.
- Requests odd-field rows one at a time over the req/in_data stream and writes each received row to the result frame memory.
- Synthesises every missing even row from the two neighbouring received rows, then writes it.
- Adds configurable geometry, pixel width and a runtime interpolation mode: 3-direction ELA, 5-direction ELA, or plain vertical average.

---
 rtl/ela_pkg.sv | 14 +
 rtl/ela_dir_select.sv | 32 +++
 rtl/ela_interp_param.sv | 99 +++++++++
 tb/tb_ela_interp_param.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ela_pkg.sv
// ela_pkg: mode encodings, FSM/direction enums and pixel helpers shared by the ELA deinterlacer.
package ela_pkg;
  localparam logic [1:0] MODE_ELA3 = 2'd0;
  localparam logic [1:0] MODE_ELA5 = 2'd1;
  localparam logic [1:0] MODE_VAVG = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;
  localparam int MAX_DW = 16;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_INTERP, S_FLUSH, S_DONE} state_e;
  typedef enum logic [2:0] {DIR_D0, DIR_D1, DIR_D2, DIR_D3, DIR_D4} dir_e;
  // Operands are zero-extended to MAX_DW so one helper serves every pixel width up to 16 bits.
  function automatic logic [MAX_DW-1:0] abs_diff(input logic [MAX_DW-1:0] a, input logic [MAX_DW-1:0] b);
    return a > b ? a - b : b - a;
  endfunction
endpackage

// File: rtl/ela_dir_select.sv
// ela_dir_select: picks the best-matching edge direction and averages that up/down pixel pair.
module ela_dir_select import ela_pkg::*; #(
  parameter int DW = 8
) (
  input  logic [4:0][DW-1:0] up,
  input  logic [4:0][DW-1:0] dn,
  input  logic [1:0]         mode,
  input  logic               edge_col,
  input  logic               near_edge,
  output logic [DW-1:0]      pix
);
  logic [4:0][DW-1:0] dd;
  logic [DW-1:0] best;
  logic [DW:0] sum;
  dir_e sel;
  // Direction k pairs up[k] with dn[4-k]; strict '<' keeps the earlier candidate on ties.
  always_comb begin
    for (int i = 0; i < 5; i++) dd[i] = DW'(abs_diff(MAX_DW'(up[i]), MAX_DW'(dn[4-i])));
    best = dd[2];
    sel = DIR_D2;
    if (!edge_col && mode != MODE_VAVG) begin
      if (dd[1] < best) begin best = dd[1]; sel = DIR_D1; end
      if (dd[3] < best) begin best = dd[3]; sel = DIR_D3; end
      if (mode == MODE_ELA5 && !near_edge) begin
        if (dd[0] < best) begin best = dd[0]; sel = DIR_D0; end
        if (dd[4] < best) begin best = dd[4]; sel = DIR_D4; end
      end
    end
    sum = {1'b0, up[sel]} + {1'b0, dn[3'd4 - sel]};
  end
  assign pix = sum[DW:1];
endmodule

// File: rtl/ela_interp_param.sv
// ela_interp_param: parametrised ELA deinterlacer; streams received rows in and writes a full frame.
module ela_interp_param import ela_pkg::*; #(
  parameter int W    = 32,
  parameter int H_IN = 16,
  parameter int DW   = 8,
  parameter int AW   = $clog2(W*(2*H_IN-1))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  output logic          req,
  input  logic [DW-1:0] in_data,
  output logic          wen,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_wr,
  input  logic [DW-1:0] data_rd,
  output logic          done
);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H_IN);
  state_e state, state_d;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [1:0] mode_q;
  logic [DW-1:0] cur [W];
  logic [DW-1:0] prv [W];
  logic [4:0][DW-1:0] up, dn;
  logic [DW-1:0] pix;
  logic c_last, r_last, unused_rd;
  assign unused_rd = ^data_rd;
  assign c_last = c == CW'(W - 1);
  assign r_last = r == RW'(H_IN - 1);
  assign req = state == S_REQ;
  assign done = state == S_DONE;
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   state_d = S_REQ;
      S_REQ:    state_d = S_RECV;
      S_RECV:   state_d = !c_last ? S_RECV : r == '0 ? S_REQ : S_INTERP;
      S_INTERP: state_d = !c_last ? S_INTERP : r_last ? S_FLUSH : S_REQ;
      S_FLUSH:  state_d = S_DONE;
      default:  state_d = S_DONE;
    endcase
  end
  function automatic logic [CW-1:0] clampc(input int j);
    return CW'(j < 0 ? 0 : j > W - 1 ? W - 1 : j);
  endfunction
  // Out-of-range neighbours are clamped; the selector ignores them via the column-class flags.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      up[i] = prv[clampc(int'(c) + i - 2)];
      dn[i] = cur[clampc(int'(c) + i - 2)];
    end
  end
  ela_dir_select #(.DW(DW)) u_dir (
    .up(up),
    .dn(dn),
    .mode(mode_q),
    .edge_col(c == '0 || c_last),
    .near_edge(c == CW'(1) || c == CW'(W - 2)),
    .pix(pix)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_d;
  // Receiving a row shifts the previous row into prv column by column, so no bulk copy is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '0;
      c <= '0;
      mode_q <= MODE_ELA3;
      wen <= 1'b0;
      addr <= '0;
      data_wr <= '0;
      for (int k = 0; k < W; k++) begin
        cur[k] <= '0;
        prv[k] <= '0;
      end
    end else begin
      wen <= state == S_RECV || state == S_INTERP;
      if (state == S_IDLE) mode_q <= mode == MODE_RSVD ? MODE_ELA3 : mode;
      if (state == S_RECV) begin
        cur[c] <= in_data;
        prv[c] <= cur[c];
        addr <= AW'(2 * int'(r) * W + int'(c));
        data_wr <= in_data;
      end
      if (state == S_INTERP) begin
        addr <= AW'((2 * int'(r) - 1) * W + int'(c));
        data_wr <= pix;
      end
      if (state == S_RECV || state == S_INTERP) begin
        c <= c_last ? '0 : c + CW'(1);
        if (c_last && (state == S_INTERP ? !r_last : r == '0)) r <= r + RW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ela_interp_param.sv
// tb_ela_interp_param: randomized self-checking bench against a behavioural ELA frame model.
module tb_ela_interp_param;
  localparam int W1 = 32, H1 = 16, DW1 = 8, N1 = W1 * (2 * H1 - 1), AW1 = $clog2(N1);
  localparam int W2 = 16, H2 = 4, DW2 = 10, N2 = W2 * (2 * H2 - 1), AW2 = $clog2(N2);
  logic clk, rst1, rst2;
  logic [1:0] mode1, mode2;
  logic req1, wen1, done1, req2, wen2, done2;
  logic [DW1-1:0] in1, wr1, rd1;
  logic [DW2-1:0] in2, wr2, rd2;
  logic [AW1-1:0] addr1;
  logic [AW2-1:0] addr2;
  int checks, errors;
  int img [H1][W1];
  int exp_f [2*H1-1][W1];
  int mem [N1];
  bit wr_flag [N1];
  int wcnt, edges1, edges2, done_at1, done_at2;
  int srow1, scol1, srow2, scol2;

  ela_interp_param #(.W(W1), .H_IN(H1), .DW(DW1)) dut1 (
    .clk(clk), .rst(rst1), .mode(mode1), .req(req1), .in_data(in1), .wen(wen1),
    .addr(addr1), .data_wr(wr1), .data_rd(rd1), .done(done1));
  ela_interp_param #(.W(W2), .H_IN(H2), .DW(DW2)) dut2 (
    .clk(clk), .rst(rst2), .mode(mode2), .req(req2), .in_data(in2), .wen(wen2),
    .addr(addr2), .data_wr(wr2), .data_rd(rd2), .done(done2));

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever @(posedge clk) begin
    edges1 = rst1 ? edges1 + 1 : 0;
    edges2 = rst2 ? edges2 + 1 : 0;
  end
  // Row sources and write monitors: a row is streamed on the W cycles that follow a req.
  initial forever @(negedge clk) begin
    if (!rst1) begin srow1 = 0; scol1 = -1; end
    else begin
      if (scol1 >= 0) begin
        in1 = DW1'(img[srow1][scol1]);
        scol1++;
        if (scol1 == W1) begin scol1 = -1; srow1++; end
      end
      if (req1) scol1 = srow1 < H1 ? 0 : -1;
      if (wen1) begin mem[addr1] = int'(wr1); wr_flag[addr1] = 1; wcnt++; end
      if (done1 && done_at1 < 0) done_at1 = edges1;
    end
    if (!rst2) begin srow2 = 0; scol2 = -1; end
    else begin
      if (scol2 >= 0) begin
        in2 = DW2'(img[srow2][scol2]);
        scol2++;
        if (scol2 == W2) begin scol2 = -1; srow2++; end
      end
      if (req2) scol2 = srow2 < H2 ? 0 : -1;
      if (wen2) begin mem[addr2] = int'(wr2); wr_flag[addr2] = 1; wcnt++; end
      if (done2 && done_at2 < 0) done_at2 = edges2;
    end
  end

  // Reference: candidates in tie-priority order, offset o pairs U[c+o] with D[c-o].
  function automatic int interp(input int r, input int c, input int w, input int m);
    int offs [5];
    int n, u, d, df, best, bu, bd;
    offs = '{0, -1, 1, -2, 2};
    if (m == 3) m = 0;
    n = (c == 0 || c == w - 1 || m == 2) ? 1 : (m == 1 && c >= 2 && c <= w - 3) ? 5 : 3;
    best = 1 << 30; bu = 0; bd = 0;
    for (int i = 0; i < n; i++) begin
      u = img[r-1][c+offs[i]];
      d = img[r][c-offs[i]];
      df = u > d ? u - d : d - u;
      if (df < best) begin best = df; bu = u; bd = d; end
    end
    return (bu + bd) / 2;
  endfunction
  function automatic void build_exp(input int w, input int h, input int m);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        exp_f[2*r][c] = img[r][c];
        if (r > 0) exp_f[2*r-1][c] = interp(r, c, w, m);
      end
  endfunction
  function automatic int bad_count(input int w, input int h, output int first, output int got, output int want);
    int n;
    n = 0; first = -1; got = 0; want = 0;
    for (int a = 0; a < w * (2 * h - 1); a++)
      if (!wr_flag[a] || mem[a] != exp_f[a/w][a%w]) begin
        if (n == 0) begin first = a; got = mem[a]; want = exp_f[a/w][a%w]; end
        n++;
      end
    return n;
  endfunction
  task automatic start(input bit second, input int m);
    @(negedge clk);
    if (second) begin rst2 = 0; mode2 = 2'(m); end
    else begin rst1 = 0; mode1 = 2'(m); end
    wcnt = 0; done_at1 = -1; done_at2 = -1;
    for (int a = 0; a < N1; a++) begin mem[a] = -1; wr_flag[a] = 0; end
    repeat (2) @(negedge clk);
    if (second) rst2 = 1; else rst1 = 1;
  endtask
  task automatic wait_done(input bit second);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((second ? done_at2 : done_at1) >= 0) break;
    end
    @(negedge clk);
  endtask
  task automatic rand_img(input int maxv);
    for (int r = 0; r < H1; r++)
      for (int c = 0; c < W1; c++) img[r][c] = int'($urandom_range(0, maxv));
  endtask

  task automatic test_reset;
    rand_img(255);
    repeat (2) @(negedge clk);
    checks++;
    if ({req1, wen1, addr1, wr1, done1} !== '0) begin
      errors++; $display("FAIL reset_outputs: got req=%b wen=%b addr=%0d data=%0d done=%b want all 0", req1, wen1, addr1, wr1, done1);
    end
    rst1 = 1;
    @(negedge clk);
    checks++;
    if (req1 !== 1'b1) begin errors++; $display("FAIL req_after_idle: got %b want 1", req1); end
    @(negedge clk);
    checks++;
    if ({req1, wen1} !== 2'b00) begin errors++; $display("FAIL req_one_cycle: got req=%b wen=%b want 0 0", req1, wen1); end
    @(negedge clk);
    checks++;
    if ({wen1, addr1, wr1} !== {1'b1, AW1'(0), DW1'(img[0][0])}) begin
      errors++; $display("FAIL first_write: got wen=%b addr=%0d data=%0d want 1 0 %0d", wen1, addr1, wr1, img[0][0]);
    end
  endtask

  task automatic test_flat;
    int nb, fa, g, w;
    for (int r = 0; r < H1; r++) for (int c = 0; c < W1; c++) img[r][c] = 'h80;
    build_exp(W1, H1, 0);
    start(0, 0); wait_done(0);
    nb = bad_count(W1, H1, fa, g, w);
    checks += 4;
    if (done_at1 != 1010) begin errors++; $display("FAIL flat done_cycle: got %0d want 1010", done_at1); end
    if (wcnt != N1) begin errors++; $display("FAIL flat wen_count: got %0d want %0d", wcnt, N1); end
    if (nb != 0) begin errors++; $display("FAIL flat frame: %0d bad, first addr %0d got %0d want %0d", nb, fa, g, w); end
    if (mem[7*W1+13] != 'h80) begin errors++; $display("FAIL flat pixel: got %0d want 128", mem[7*W1+13]); end
  endtask

  // Step edge whose boundary moves two columns left per received row (one per output row).
  task automatic test_antidiag;
    int nb, fa, g, w, m, want;
    for (int r = 0; r < H1; r++) for (int c = 0; c < W1; c++) img[r][c] = c >= 30 - 2 * r ? 'hFF : 0;
    for (int k = 0; k < 2; k++) begin
      m = k == 0 ? 0 : 2;
      want = m == 0 ? 'hFF : 'h7F;
      build_exp(W1, H1, m);
      start(0, m); wait_done(0);
      nb = bad_count(W1, H1, fa, g, w);
      checks += 3;
      if (done_at1 != 1010) begin errors++; $display("FAIL antidiag m%0d done_cycle: got %0d want 1010", m, done_at1); end
      if (nb != 0) begin errors++; $display("FAIL antidiag m%0d frame: %0d bad, first addr %0d got %0d want %0d", m, nb, fa, g, w); end
      if (mem[9*W1+21] != want) begin errors++; $display("FAIL antidiag m%0d step: got %0d want %0d", m, mem[9*W1+21], want); end
    end
  endtask

  task automatic test_tie;
    int nb, fa, g, w, a, want;
    rand_img(255);
    for (int c = 0; c < 3; c++) begin img[0][c] = 10 * (c + 1); img[1][c] = 10 * (3 - c); end
    for (int c = 0; c < 5; c++) begin img[2][c] = 10 * (c + 1); img[3][c] = 10 * (5 - c); end
    for (int m = 0; m < 2; m++) begin
      a = m == 0 ? W1 + 1 : 5 * W1 + 2;
      want = m == 0 ? 20 : 30;
      build_exp(W1, H1, m);
      start(0, m); wait_done(0);
      nb = bad_count(W1, H1, fa, g, w);
      checks += 2;
      if (nb != 0) begin errors++; $display("FAIL tie m%0d frame: %0d bad, first addr %0d got %0d want %0d", m, nb, fa, g, w); end
      if (mem[a] != want) begin errors++; $display("FAIL tie m%0d pick: got %0d want %0d", m, mem[a], want); end
    end
  endtask

  task automatic test_ela5_steep;
    int nb, fa, g, w, want;
    for (int r = 0; r < H1; r++) for (int c = 0; c < W1; c++) img[r][c] = c >= 26 - 4 * (r % 6) ? 200 : 50;
    for (int m = 1; m >= 0; m--) begin
      want = m == 1 ? 200 : 125;
      build_exp(W1, H1, m);
      start(0, m); wait_done(0);
      nb = bad_count(W1, H1, fa, g, w);
      checks += 2;
      if (nb != 0) begin errors++; $display("FAIL steep m%0d frame: %0d bad, first addr %0d got %0d want %0d", m, nb, fa, g, w); end
      if (mem[W1+24] != want) begin errors++; $display("FAIL steep m%0d pick: got %0d want %0d", m, mem[W1+24], want); end
    end
  endtask

  // Mode is altered mid-frame; the frame must follow the mode captured at start.
  task automatic test_random;
    int nb, fa, g, w, m;
    for (int k = 0; k < 3; k++) begin
      rand_img(255);
      m = int'($urandom_range(0, 3));
      build_exp(W1, H1, m);
      start(0, m);
      repeat (20) @(negedge clk);
      mode1 = 2'(m + 1);
      wait_done(0);
      nb = bad_count(W1, H1, fa, g, w);
      checks += 3;
      if (done_at1 != 1010) begin errors++; $display("FAIL random m%0d done_cycle: got %0d want 1010", m, done_at1); end
      if (wcnt != N1) begin errors++; $display("FAIL random m%0d wen_count: got %0d want %0d", m, wcnt, N1); end
      if (nb != 0) begin errors++; $display("FAIL random m%0d frame: %0d bad, first addr %0d got %0d want %0d", m, nb, fa, g, w); end
    end
  endtask

  task automatic test_mid_reset;
    int nb, fa, g, w;
    bit hit;
    rand_img(255);
    build_exp(W1, H1, 1);
    start(0, 1);
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      hit = wen1 && addr1 == AW1'(9 * W1 + 5);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midreset reach_row5: got no write to %0d want one", 9 * W1 + 5); end
    #2 rst1 = 0;
    #1;
    checks++;
    if ({req1, wen1, addr1, wr1, done1} !== '0) begin
      errors++; $display("FAIL midreset async_clear: got req=%b wen=%b addr=%0d data=%0d done=%b want all 0", req1, wen1, addr1, wr1, done1);
    end
    start(0, 1); wait_done(0);
    nb = bad_count(W1, H1, fa, g, w);
    checks += 3;
    if (done_at1 != 1010) begin errors++; $display("FAIL midreset done_cycle: got %0d want 1010", done_at1); end
    if (wcnt != N1) begin errors++; $display("FAIL midreset wen_count: got %0d want %0d", wcnt, N1); end
    if (nb != 0) begin errors++; $display("FAIL midreset frame: %0d bad, first addr %0d got %0d want %0d", nb, fa, g, w); end
  endtask

  task automatic test_param_sweep;
    int nb, fa, g, w;
    rand_img(1023);
    build_exp(W2, H2, 2);
    start(1, 2); wait_done(1);
    nb = bad_count(W2, H2, fa, g, w);
    checks += 4;
    if (done_at2 != 118) begin errors++; $display("FAIL sweep done_cycle: got %0d want 118", done_at2); end
    if (wcnt != N2) begin errors++; $display("FAIL sweep wen_count: got %0d want %0d", wcnt, N2); end
    if (nb != 0) begin errors++; $display("FAIL sweep frame: %0d bad, first addr %0d got %0d want %0d", nb, fa, g, w); end
    if (mem[W2+3] != (img[0][3] + img[1][3]) / 2) begin
      errors++; $display("FAIL sweep avg: got %0d want %0d", mem[W2+3], (img[0][3] + img[1][3]) / 2);
    end
  endtask

  initial begin
    rst1 = 0; rst2 = 0; mode1 = 0; mode2 = 0; in1 = 0; in2 = 0; rd1 = 0; rd2 = 0;
    checks = 0; errors = 0; wcnt = 0; done_at1 = -1; done_at2 = -1;
    test_reset;
    test_flat;
    test_antidiag;
    test_tie;
    test_ela5_steep;
    test_random;
    test_mid_reset;
    test_param_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
